// File: rtl/rf_sequencer.sv
// rf_sequencer: runs one register-file instruction per start request.
// A non-LOADI instruction reads both operands, executes, writes back and then
// pulses done. LOADI skips the read and execute steps and writes imm directly.
//
// Handshake: start is a request that is only looked at while the FSM is idle.
// The instruction fields are captured on the rising edge that sees start=1 in
// IDLE. While busy or done is high, start is ignored, so it may stay high.
// The next request is accepted once both busy and done are low again.
module rf_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [1:0] src_a,
    input  logic [1:0] src_b,
    input  logic [1:0] dst,
    input  logic [3:0] imm,
    input  logic [3:0] rf_douta,
    input  logic [3:0] rf_doutb,
    output logic       rf_rea,
    output logic       rf_reb,
    output logic [1:0] rf_raa,
    output logic [1:0] rf_rab,
    output logic       rf_we,
    output logic [1:0] rf_wa,
    output logic [3:0] rf_din,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       carry,
    output logic       zero,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] OP_LOADI = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_XOR   = 3'b101;
    localparam logic [2:0] OP_NOTA  = 3'b110;
    localparam logic [2:0] OP_MOVA  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state;
    logic [2:0] op_q;
    logic [3:0] opa_q;
    logic [3:0] opb_q;

    logic [4:0] sum;
    logic [4:0] diff;
    logic [3:0] alu_res;
    logic       alu_carry;

    // The write data is the registered result, so the written value and the result output always agree.
    assign rf_din    = result;
    assign dbg_state = state;

    // The ALU works on the operands registered at the end of READ and the latched opcode.
    always_comb begin
        sum       = {1'b0, opa_q} + {1'b0, opb_q};
        diff      = {1'b0, opa_q} - {1'b0, opb_q};
        alu_res   = 4'd0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD:  begin alu_res = sum[3:0];  alu_carry = sum[4];  end
            OP_SUB:  begin alu_res = diff[3:0]; alu_carry = diff[4]; end
            OP_AND:  alu_res = opa_q & opb_q;
            OP_OR:   alu_res = opa_q | opb_q;
            OP_XOR:  alu_res = opa_q ^ opb_q;
            OP_NOTA: alu_res = ~opa_q;
            OP_MOVA: alu_res = opa_q;
            default: alu_res = 4'd0;
        endcase
    end

    // Sequencer FSM. All outputs are registered and change together with the state.
    // The immediate is consumed on acceptance, and the result register holds it from then on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= 3'd0;
            opa_q  <= 4'd0;
            opb_q  <= 4'd0;
            rf_rea <= 1'b0;
            rf_reb <= 1'b0;
            rf_raa <= 2'd0;
            rf_rab <= 2'd0;
            rf_we  <= 1'b0;
            rf_wa  <= 2'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 4'd0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            rf_rea <= 1'b0;
            rf_reb <= 1'b0;
            rf_we  <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        rf_raa <= src_a;
                        rf_rab <= src_b;
                        rf_wa  <= dst;
                        busy   <= 1'b1;
                        if (op == OP_LOADI) begin
                            result <= imm;
                            carry  <= 1'b0;
                            zero   <= (imm == 4'd0);
                            rf_we  <= 1'b1;
                            state  <= S_WRITE;
                        end else begin
                            rf_rea <= 1'b1;
                            rf_reb <= 1'b1;
                            state  <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    opa_q <= rf_douta;
                    opb_q <= rf_doutb;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    result <= alu_res;
                    carry  <= alu_carry;
                    zero   <= (alu_res == 4'd0);
                    rf_we  <= 1'b1;
                    state  <= S_WRITE;
                end
                S_WRITE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer: a 4x4 register file, an instruction driver, a
// reference model that predicts each write, and a monitor that checks writes,
// latency and done pulses against the expected queue.
module tb_rf_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic [1:0] src_a, src_b, dst;
    logic [3:0] imm;
    logic [3:0] rf_douta, rf_doutb;
    logic       rf_rea, rf_reb;
    logic [1:0] rf_raa, rf_rab;
    logic       rf_we;
    logic [1:0] rf_wa;
    logic [3:0] rf_din;
    logic       busy, done;
    logic [3:0] result;
    logic       carry, zero;
    logic [2:0] dbg_state;

    rf_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .dst(dst), .imm(imm),
        .rf_douta(rf_douta), .rf_doutb(rf_doutb),
        .rf_rea(rf_rea), .rf_reb(rf_reb), .rf_raa(rf_raa), .rf_rab(rf_rab),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_din(rf_din),
        .busy(busy), .done(done), .result(result),
        .carry(carry), .zero(zero), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- register file ----------------
    logic [3:0] rf_mem [4];
    logic [3:0] model_rf [4];
    logic       tb_we;
    logic [1:0] tb_wa;
    logic [3:0] tb_wd;

    always @(posedge clk) begin
        if (rf_we)      rf_mem[rf_wa] <= rf_din;
        else if (tb_we) rf_mem[tb_wa] <= tb_wd;
    end
    assign rf_douta = rf_mem[rf_raa];
    assign rf_doutb = rf_mem[rf_rab];

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];   // {wa, din, carry, zero}
    int         exp_cyc_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int we_count = 0;
    int done_count = 0;
    logic prev_we = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: the value, carry and zero an instruction produces.
    function automatic logic [5:0] ref_model(input int opc, input int a, input int b, input int im);
        int r;
        int c;
        r = 0;
        c = 0;
        case (opc)
            0: r = im;
            1: begin r = a + b; c = (r > 15) ? 1 : 0; r = r % 16; end
            2: begin c = (a < b) ? 1 : 0; r = (a - b + 16) % 16; end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = 15 - a;
            default: r = a;
        endcase
        return {r[3:0], c[0], (r == 0)};
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [7:0] e;
        int ec;
        #1;
        if (prev_we)
            check("done_after_write", done, rst_n ? 1 : 0);
        else if (done)
            check("done_without_write", 1, 0);
        if (rf_we) begin
            we_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("write_addr", rf_wa, e[7:6]);
                check("write_data", rf_din, e[5:2]);
                check("result", result, e[5:2]);
                check("carry", carry, e[1]);
                check("zero", zero, e[0]);
                check("write_latency", cyc, ec);
            end
        end
        if (done) done_count++;
        prev_we = rf_we;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            if (!busy && !done) return;
            @(negedge clk);
        end
        check("idle_timeout", 0, 1);
    endtask

    task automatic preload(input int r, input int v);
        wait_idle();
        tb_we = 1'b1;
        tb_wa = r[1:0];
        tb_wd = v[3:0];
        model_rf[r] = v[3:0];
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic issue(input int opc, input int a, input int b, input int d,
                         input int im, input int hold);
        logic [5:0] m;
        wait_idle();
        m = ref_model(opc, model_rf[a], model_rf[b], im);
        model_rf[d] = m[5:2];
        exp_q.push_back({d[1:0], m});
        exp_cyc_q.push_back(cyc + 1 + ((opc == 0) ? 0 : 2));
        op    = opc[2:0];
        src_a = a[1:0];
        src_b = b[1:0];
        dst   = d[1:0];
        imm   = im[3:0];
        start = 1'b1;
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            op    = 3'($urandom_range(0, 7));
            src_a = 2'($urandom_range(0, 3));
            src_b = 2'($urandom_range(0, 3));
            dst   = 2'($urandom_range(0, 3));
            imm   = 4'($urandom_range(0, 15));
        end
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w0, d0, o, h;
        rst_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        dst = '0; imm = '0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        for (int i = 0; i < 4; i++) begin rf_mem[i] = 4'd0; model_rf[i] = 4'd0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              int'({rf_rea, rf_reb, rf_raa, rf_rab, rf_we, rf_wa, rf_din, busy, done, result, carry, zero}), 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;

        // LOADI r2 <- 9
        issue(0, 0, 0, 2, 9, 1);
        // ADD overflow: 9 + 8
        preload(0, 9); preload(1, 8);
        issue(1, 0, 1, 3, 0, 1);
        // SUB borrow, then SUB to zero
        preload(0, 3); preload(1, 5);
        issue(2, 0, 1, 3, 0, 1);
        issue(2, 0, 0, 3, 0, 1);
        // start held high through an ADD, including the DONE cycle
        wait_idle();
        w0 = we_count; d0 = done_count;
        issue(1, 0, 1, 2, 0, 5);
        wait_idle();
        check("held_start_writes", we_count - w0, 1);
        check("held_start_dones", done_count - d0, 1);
        issue(4, 0, 1, 1, 0, 1);
        // in-place XOR clears r2
        preload(2, 6);
        issue(5, 2, 2, 2, 0, 1);
        wait_idle();
        @(negedge clk);
        check("inplace_r2", rf_mem[2], 0);

        // randomized instructions
        for (int n = 0; n < 60; n++) begin
            o = $urandom_range(0, 7);
            h = $urandom_range(1, 3);
            issue(o, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 15), h);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // reset during the WRITE cycle of an ADD
        preload(0, 7); preload(1, 4);
        d0 = done_count;
        issue(1, 0, 1, 1, 0, 1);
        for (int k = 0; k < 10 && !rf_we; k++) @(negedge clk);
        check("reached_write", rf_we, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_we", rf_we, 0);
        check("abort_busy", busy, 0);
        check("abort_outputs",
              int'({rf_rea, rf_reb, rf_raa, rf_rab, rf_we, rf_wa, rf_din, busy, done, result, carry, zero}), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_count - d0, 0);
        // first start after reset is accepted
        issue(0, 0, 0, 3, 0, 1);
        issue(3, 0, 1, 2, 0, 1);
        wait_idle();
        repeat (2) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) check("final_rf", rf_mem[i], model_rf[i]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
